// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into aligned word accesses,
// with read-modify-write for sub-word stores and sign/zero extension on loads.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned AW = 33;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    state_e      state_q;
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic [1:0]  resp_err_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_re_q;
    logic        mem_we_q;

    logic [31:0] word_addr_c;
    logic        misalign_c;
    logic        range_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] load_c;
    logic [31:0] merge_c;

    assign word_addr_c = {req_addr[31:2], 2'b00};
    assign misalign_c  = (req_size == 2'b11)
                      || (req_size == 2'b01 && req_addr[0])
                      || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    // 33-bit sum so addresses near the top of the space cannot wrap into range
    assign range_c     = (AW'({1'b0, word_addr_c}) + AW'(4)) > AW'(MEM_BYTES);

    assign byte_c = 8'(mem_rdata >> {lane_q, 3'b000});
    assign half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_c = mem_rdata;
        case (size_q)
            2'b00:   load_c = signed_q ? {{24{byte_c[7]}}, byte_c} : {24'h0, byte_c};
            2'b01:   load_c = signed_q ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
            default: load_c = mem_rdata;
        endcase
    end

    // Sub-word store: splice the new lane(s) into the word just read
    always_comb begin
        merge_c = mem_rdata;
        case (size_q)
            2'b00: begin
                case (lane_q)
                    2'd0:    merge_c[7:0]   = wdata_q[7:0];
                    2'd1:    merge_c[15:8]  = wdata_q[7:0];
                    2'd2:    merge_c[23:16] = wdata_q[7:0];
                    default: merge_c[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (lane_q[1]) merge_c[31:16] = wdata_q;
                else           merge_c[15:0]  = wdata_q;
            end
            default: merge_c = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 2'b00;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        lane_q   <= req_addr[1:0];
                        wdata_q  <= req_wdata[15:0];
                        ready_q  <= 1'b0;
                        if (misalign_c || range_c) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= {range_c & ~misalign_c, misalign_c};
                        end else if (req_write && req_size == 2'b10) begin
                            state_q     <= WR;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= word_addr_c;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= RD;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= word_addr_c;
                        end
                    end
                end
                RD: begin
                    mem_re_q <= 1'b0;
                    if (write_q) begin
                        state_q     <= WR;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merge_c;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_c;
                    end
                end
                WR: begin
                    mem_we_q     <= 1'b0;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 2'b00;
                    ready_q      <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small behavioural data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(25)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Data memory: 8 words, combinational read, word write on the edge
    logic [31:0] mem [0:7];
    logic        init_mem;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 8; i++)
                mem[i] <= (i == 1) ? 32'h8899AABB : (i == 5) ? 32'h13572468 : 32'h0;
        end else if (mem_we) begin
            mem[mem_addr[4:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_re ? mem[mem_addr[4:2]] : 32'h0;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  err;
        int          cyc;
        int          tag;
    } exp_t;

    exp_t        expq[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          tag = 0;
    int          re_cnt = 0;
    int          we_cnt = 0;
    int          both_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: memory activity counters and scoreboard pops on resp_valid
    always @(negedge clk) begin
        if (mem_re) begin re_cnt++; last_addr = mem_addr; end
        if (mem_we) begin we_cnt++; last_addr = mem_addr; last_wdata = mem_wdata; end
        if (mem_re && mem_we) both_cnt++;
        if (resp_valid) begin
            resp_cnt++;
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
            end else begin
                e = expq.pop_front();
                check32($sformatf("t%0d resp_rdata", e.tag), resp_rdata, e.rd);
                check32($sformatf("t%0d resp_err", e.tag), 32'(resp_err), 32'(e.err));
                check32($sformatf("t%0d resp_cycle", e.tag), 32'(cycle), 32'(e.cyc));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL wait_ready: got req_ready=0 expected 1");
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        req_valid  = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (expq.size() != 0 && n < 10);
        if (expq.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL resp_timeout: got %0d pending expected 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic run(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic [1:0] exp_err, input int lat,
                       input int exp_re, input int exp_we, input logic [31:0] exp_word);
        exp_t x;
        wait_ready();
        drive(w, sz, sg, ad, wd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        re_cnt = 0; we_cnt = 0; both_cnt = 0;
        tag++;
        x.rd = exp_rd; x.err = exp_err; x.cyc = cycle + lat - 1; x.tag = tag;
        expq.push_back(x);
        drain();
        check32($sformatf("t%0d mem_re_cycles", tag), 32'(re_cnt), 32'(exp_re));
        check32($sformatf("t%0d mem_we_cycles", tag), 32'(we_cnt), 32'(exp_we));
        check32($sformatf("t%0d re_we_overlap", tag), 32'(both_cnt), 32'h0);
        if (exp_re + exp_we > 0)
            check32($sformatf("t%0d mem_addr", tag), last_addr, {ad[31:2], 2'b00});
        if (exp_we > 0)
            check32($sformatf("t%0d mem_wdata", tag), last_wdata, exp_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        int rc;
        exp_t x;
        rst = 1'b1; init_mem = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst resp_valid", 32'(resp_valid), 32'h0);
        check32("rst resp_rdata", resp_rdata, 32'h0);
        check32("rst resp_err", 32'(resp_err), 32'h0);
        check32("rst mem_re", 32'(mem_re), 32'h0);
        check32("rst mem_we", 32'(mem_we), 32'h0);
        check32("rst mem_addr", mem_addr, 32'h0);
        check32("rst mem_wdata", mem_wdata, 32'h0);
        check32("rst req_ready", 32'(req_ready), 32'h1);
        init_mem = 1'b0;
        rst = 1'b0;

        // Loads from the preloaded word 0x8899AABB at 4
        run(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h8899AABB, 2'b00, 2, 1, 0, 32'h0);
        run(1'b0, 2'b00, 1'b1, 32'd7, 32'h0, 32'hFFFFFF88, 2'b00, 2, 1, 0, 32'h0);
        run(1'b0, 2'b00, 1'b0, 32'd7, 32'h0, 32'h00000088, 2'b00, 2, 1, 0, 32'h0);
        run(1'b0, 2'b01, 1'b1, 32'd6, 32'h0, 32'hFFFF8899, 2'b00, 2, 1, 0, 32'h0);
        run(1'b0, 2'b01, 1'b0, 32'd4, 32'h0, 32'h0000AABB, 2'b00, 2, 1, 0, 32'h0);
        run(1'b0, 2'b00, 1'b1, 32'd4, 32'h0, 32'hFFFFFFBB, 2'b00, 2, 1, 0, 32'h0);

        // Sub-word and word stores, read back
        run(1'b1, 2'b00, 1'b0, 32'd5, 32'h123456CC, 32'h0, 2'b00, 3, 1, 1, 32'h8899CCBB);
        run(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h8899CCBB, 2'b00, 2, 1, 0, 32'h0);
        run(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 32'h0, 2'b00, 2, 0, 1, 32'hDEADBEEF);
        run(1'b1, 2'b01, 1'b0, 32'd10, 32'hFFFF5A5A, 32'h0, 2'b00, 3, 1, 1, 32'h5A5ABEEF);
        run(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, 32'h5A5ABEEF, 2'b00, 2, 1, 0, 32'h0);

        // Errors and range boundary
        run(1'b1, 2'b01, 1'b0, 32'd3, 32'h0, 32'h0, 2'b01, 1, 0, 0, 32'h0);
        run(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 32'h0, 2'b01, 1, 0, 0, 32'h0);
        run(1'b0, 2'b10, 1'b0, 32'd24, 32'h0, 32'h0, 2'b10, 1, 0, 0, 32'h0);
        run(1'b0, 2'b10, 1'b0, 32'd20, 32'h0, 32'h13572468, 2'b00, 2, 1, 0, 32'h0);
        run(1'b0, 2'b01, 1'b0, 32'd25, 32'h0, 32'h0, 2'b01, 1, 0, 0, 32'h0);
        run(1'b0, 2'b00, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 2'b10, 1, 0, 0, 32'h0);

        // Reset during the write cycle of a byte store
        wait_ready();
        drive(1'b1, 2'b00, 1'b0, 32'd4, 32'h000000EE);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rc = resp_cnt;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_we && n < 10);
        check32("abort mem_we_seen", 32'(mem_we), 32'h1);
        rst = 1'b1;
        #1;
        check32("abort mem_we_drop", 32'(mem_we), 32'h0);
        check32("abort mem_re_drop", 32'(mem_re), 32'h0);
        check32("abort req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check32("abort mem_word", mem[1], 32'h8899CCBB);
        check32("abort req_ready_hold", 32'(req_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check32("abort no_resp", 32'(resp_cnt), 32'(rc));
        run(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h8899CCBB, 2'b00, 2, 1, 0, 32'h0);

        // Back-to-back with req_valid held: accepted only in IDLE
        wait_ready();
        drive(1'b0, 2'b10, 1'b0, 32'd20, 32'h0);
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (req_ready) begin
                acc++;
                tag++;
                x.rd = 32'h13572468; x.err = 2'b00; x.cyc = cycle + 2; x.tag = tag;
                expq.push_back(x);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        drain();
        check32("b2b accepts", 32'(acc), 32'd2);

        repeat (3) @(negedge clk);
        check32("final queue_empty", 32'(expq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline memory stage and the byte-addressed, little-endian 32-bit data memory. That memory reads combinationally when its read enable is high and writes a full word on the clock edge when its write enable is high.
- Converts byte, halfword and word load/store requests into aligned word accesses.
- Performs read-modify-write for sub-word stores, and sign- or zero-extends sub-word loads.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 25, number of bytes in data memory; an aligned word access at address A is legal only if A+4 <= MEM_BYTES.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend sub-word load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bits used for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  2  bit0 misaligned/illegal size, bit1 out of range
- mem_addr  out  32  aligned word address to data memory
- mem_wdata  out  32  write word to data memory
- mem_re  out  1  data memory read enable
- mem_we  out  1  data memory write enable
- mem_rdata  in  32  data memory read word (combinational)

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset state IDLE. On reset: resp_valid=0, resp_rdata=0, resp_err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=1.
- Acceptance: req_valid && req_ready at a rising edge. The unit latches write, size, signed, addr and wdata.
- Definitions: A = {addr[31:2],2'b00}; lane = addr[1:0].
- Error checks are made at acceptance; misalign takes priority over range:
  - Misaligned (bit0) if size==11, or half with addr[0]=1, or word with lane!=0.
  - Out of range (bit1) if A+4 > MEM_BYTES, computed 33-bit with no wrap.
  - On error, next state is RESP with resp_err set. No mem_re/mem_we is ever asserted.
- States and transitions:
  - IDLE -> RD for a load or a sub-word store.
  - IDLE -> WR for a word store.
  - IDLE -> RESP on error.
  - RD: mem_re=1, mem_addr=A. At the edge, mem_rdata is captured. Load -> RESP; sub-word store -> WR.
  - WR: mem_we=1, mem_addr=A, mem_wdata=merged word. Memory writes at the edge. Then -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
- Latency: count edges from the acceptance edge to the cycle in which resp_valid is high.
  - Error: 1.
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
- Store merge:
  - Byte: captured word with bits [8*lane+7:8*lane] replaced by wdata[7:0].
  - Half: addr[1]=0 replaces [15:0]; addr[1]=1 replaces [31:16]; replacement is wdata[15:0].
  - Word: wdata unchanged.
- Load extract: select the lane byte or half, then sign-extend if req_signed, else zero-extend. Word loads ignore req_signed.
- mem_re and mem_we are never high together. Both are 0 in IDLE and RESP.
- resp_rdata, resp_err and resp_valid are registered. resp_rdata and resp_err return to 0 when resp_valid falls.
- A req_valid seen while not in IDLE is ignored. The requester must hold it until accepted.
- Reset mid-operation: the state returns to IDLE immediately. mem_we and mem_re fall combinationally. An in-flight write whose edge has not yet occurred is not performed, and no resp_valid is produced for the aborted request.

Test Plan:
- Preload word 0x8899AABB at address 4. Load word at addr 4 -> resp_rdata=0x8899AABB, resp_err=00, resp_valid 2 edges after acceptance, mem_re high exactly one cycle with mem_addr=4.
- Signed byte load at 7 -> 0xFFFFFF88. Unsigned byte load at 7 -> 0x00000088. Signed half load at 6 -> 0xFFFF8899. Unsigned half load at 4 -> 0x0000AABB.
- Byte store of 0x123456CC to addr 5 -> one mem_re cycle, then one mem_we cycle with mem_addr=4 and mem_wdata=0x8899CCBB, resp_valid 3 edges after acceptance. A following word load at 4 returns 0x8899CCBB.
- Half store to addr 3 -> resp_err=01, resp_valid 1 edge after acceptance, mem_re and mem_we never asserted. A request with size=11 -> resp_err=01.
- Word load at 24 -> resp_err=10, no memory access. Word load at 20 -> resp_err=00. Half load at 25 (misaligned and out of range) -> resp_err=01.
- Assert rst during the WR cycle of a byte store -> mem_we drops before the edge, memory word is unchanged, no resp_valid is produced, and req_ready=1 while rst is high. Back-to-back requests with req_valid held high are each accepted only in IDLE.
